// File: rtl/int8_16x16_stream_driver_if.sv
// Stream bundle between the host-side driver (master) and the matrix engine (slave).
// A and B flow driver -> engine, C flows engine -> driver.
// With DRIVER_TLAST_EN defined each stream also carries a tlast bit.
interface int8_16x16_stream_driver_if;
  logic [127:0] a_tdata;
  logic         a_tvalid;
  logic         a_tready;
  logic [127:0] b_tdata;
  logic         b_tvalid;
  logic         b_tready;
  logic [255:0] c_tdata;
  logic         c_tvalid;
  logic         c_tready;
`ifdef DRIVER_TLAST_EN
  logic         a_tlast;
  logic         b_tlast;
  logic         c_tlast;

  modport master (
    output a_tdata, a_tvalid, a_tlast, b_tdata, b_tvalid, b_tlast, c_tready,
    input  a_tready, b_tready, c_tdata, c_tvalid, c_tlast
  );

  modport slave (
    input  a_tdata, a_tvalid, a_tlast, b_tdata, b_tvalid, b_tlast, c_tready,
    output a_tready, b_tready, c_tdata, c_tvalid, c_tlast
  );
`else
  modport master (
    output a_tdata, a_tvalid, b_tdata, b_tvalid, c_tready,
    input  a_tready, b_tready, c_tdata, c_tvalid
  );

  modport slave (
    input  a_tdata, a_tvalid, b_tdata, b_tvalid, c_tready,
    output a_tready, b_tready, c_tdata, c_tvalid
  );
`endif
endinterface

// File: rtl/int8_16x16_stream_driver.sv
// Host-side initiator for the 16x16 int8 matmul stream engine: holds A rows and B columns,
// streams them out on start, collects 16 C rows into a readable buffer, and reports run
// latency and timeout. Optional macro DRIVER_TLAST_EN adds tlast on all streams and a
// sticky tlast_err status for misplaced C tlast.
module int8_16x16_stream_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         i_ap_clk,
  input  logic         i_ap_rst,
  input  logic         i_ld_we,
  input  logic         i_ld_sel,
  input  logic [3:0]   i_ld_addr,
  input  logic [127:0] i_ld_data,
  input  logic         i_ap_start,
  output logic         o_busy,
  output logic         o_ap_done,
  output logic         o_timeout,
  output logic [31:0]  o_cycles,
  input  logic [3:0]   i_rd_addr,
  output logic [255:0] o_rd_data,
`ifdef DRIVER_TLAST_EN
  output logic         o_tlast_err,
`endif
  int8_16x16_stream_driver_if.master m_axis
);

  localparam int unsigned BEATS   = 16;
  localparam logic [4:0]  CntFull = 5'(BEATS);
  localparam logic [4:0]  CntLast = 5'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       r_state, w_state_d;
  logic [127:0] r_abuf [BEATS];
  logic [127:0] r_bbuf [BEATS];
  logic [255:0] r_cbuf [BEATS];
  logic [4:0]   r_a_cnt, r_b_cnt, r_c_cnt;
  logic [4:0]   w_a_cnt_d, w_b_cnt_d, w_c_cnt_d;
  logic [31:0]  r_run_cnt;
  logic [31:0]  r_cycles;
  logic         r_timeout;
  logic [255:0] r_rd_data;
  logic         w_run, w_start, w_load;
  logic         w_a_fire, w_b_fire, w_c_fire;
  logic         w_all_done, w_time_up;
`ifdef DRIVER_TLAST_EN
  logic         r_tlast_err;
`endif

  assign w_run   = (r_state == StRun);
  assign w_start = (r_state == StIdle) && i_ap_start;
  assign w_load  = (r_state == StIdle) && i_ld_we && !i_ap_rst;

  // Counter index wraps to row 0 once a stream is exhausted, which also gives row 0 at reset.
  assign m_axis.a_tvalid = w_run && (r_a_cnt < CntFull);
  assign m_axis.a_tdata  = r_abuf[r_a_cnt[3:0]];
  assign m_axis.b_tvalid = w_run && (r_b_cnt < CntFull);
  assign m_axis.b_tdata  = r_bbuf[r_b_cnt[3:0]];
  assign m_axis.c_tready = w_run && (r_c_cnt < CntFull);
`ifdef DRIVER_TLAST_EN
  assign m_axis.a_tlast  = m_axis.a_tvalid && (r_a_cnt == CntLast);
  assign m_axis.b_tlast  = m_axis.b_tvalid && (r_b_cnt == CntLast);
  assign o_tlast_err     = r_tlast_err;
`endif

  assign w_a_fire = m_axis.a_tvalid && m_axis.a_tready;
  assign w_b_fire = m_axis.b_tvalid && m_axis.b_tready;
  assign w_c_fire = m_axis.c_tready && m_axis.c_tvalid;

  assign o_busy    = w_run;
  assign o_ap_done = (r_state == StDone);
  assign o_timeout = r_timeout;
  assign o_cycles  = r_cycles;
  assign o_rd_data = r_rd_data;

  // Next-state: completion looks at post-handshake counts so the run ends on the last beat.
  always_comb begin
    w_state_d  = r_state;
    w_a_cnt_d  = r_a_cnt + {4'd0, w_a_fire};
    w_b_cnt_d  = r_b_cnt + {4'd0, w_b_fire};
    w_c_cnt_d  = r_c_cnt + {4'd0, w_c_fire};
    w_all_done = (w_a_cnt_d == CntFull) && (w_b_cnt_d == CntFull) && (w_c_cnt_d == CntFull);
    w_time_up  = (r_run_cnt == 32'(TIMEOUT_CYCLES - 1));
    unique case (r_state)
      StIdle:  if (i_ap_start) w_state_d = StRun;
      StRun:   if (w_all_done || w_time_up) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State, beat counters and run status.
  always_ff @(posedge i_ap_clk) begin
    if (i_ap_rst) begin
      r_state   <= StIdle;
      r_a_cnt   <= '0;
      r_b_cnt   <= '0;
      r_c_cnt   <= '0;
      r_run_cnt <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
`ifdef DRIVER_TLAST_EN
      r_tlast_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_a_cnt   <= '0;
        r_b_cnt   <= '0;
        r_c_cnt   <= '0;
        r_run_cnt <= '0;
        r_cycles  <= '0;
        r_timeout <= 1'b0;
`ifdef DRIVER_TLAST_EN
        r_tlast_err <= 1'b0;
`endif
      end else if (w_run) begin
        r_a_cnt   <= w_a_cnt_d;
        r_b_cnt   <= w_b_cnt_d;
        r_c_cnt   <= w_c_cnt_d;
        r_run_cnt <= r_run_cnt + 32'd1;
        if (w_state_d == StDone) begin
          r_cycles  <= r_run_cnt + 32'd1;
          r_timeout <= !w_all_done;
        end
`ifdef DRIVER_TLAST_EN
        if (w_c_fire && (m_axis.c_tlast != (r_c_cnt == CntLast))) r_tlast_err <= 1'b1;
`endif
      end
    end
  end

  // Buffer storage (not reset): host loads in IDLE, engine results land as they arrive.
  always_ff @(posedge i_ap_clk) begin
    if (w_load && !i_ld_sel) r_abuf[i_ld_addr] <= i_ld_data;
    if (w_load && i_ld_sel)  r_bbuf[i_ld_addr] <= i_ld_data;
    if (w_c_fire && !i_ap_rst) r_cbuf[r_c_cnt[3:0]] <= m_axis.c_tdata;
  end

  // Registered result read port, active in every state.
  always_ff @(posedge i_ap_clk) begin
    if (i_ap_rst) r_rd_data <= '0;
    else          r_rd_data <= r_cbuf[i_rd_addr];
  end

endmodule

// File: tb/tb_int8_16x16_stream_driver.sv
// Directed bench for int8_16x16_stream_driver (TIMEOUT_CYCLES = 64).
module tb_int8_16x16_stream_driver;

  logic         clk;
  logic         rst;
  logic         ld_we;
  logic         ld_sel;
  logic [3:0]   ld_addr;
  logic [127:0] ld_data;
  logic         ap_start;
  logic         busy;
  logic         ap_done;
  logic         timeout_o;
  logic [31:0]  cycles;
  logic [3:0]   rd_addr;
  logic [255:0] rd_data;
`ifdef DRIVER_TLAST_EN
  logic         tlast_err;
`endif

  int total;
  int bad;
  int dc;
  logic [127:0] exp_a [16];
  logic [127:0] exp_b [16];

  int8_16x16_stream_driver_if sif ();

  int8_16x16_stream_driver #(.TIMEOUT_CYCLES(64)) dut (
    .i_ap_clk   (clk),
    .i_ap_rst   (rst),
    .i_ld_we    (ld_we),
    .i_ld_sel   (ld_sel),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .i_ap_start (ap_start),
    .o_busy     (busy),
    .o_ap_done  (ap_done),
    .o_timeout  (timeout_o),
    .o_cycles   (cycles),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
`ifdef DRIVER_TLAST_EN
    .o_tlast_err(tlast_err),
`endif
    .m_axis     (sif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a run and plays the engine side; returns the RUN cycle on which ap_done was seen,
  // or -1 when it leaves early after rst_after accepted A beats.
  task automatic do_run(input bit a_bp, input bit c_on, input bit ld_mid, input int rst_after,
                        input bit c_last_bad, output int done_cyc);
    int na;
    int nb;
    int nc;
    bit early;
    na = 0; nb = 0; nc = 0; early = 1'b0; done_cyc = -1;
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_a_tvalid", sif.a_tvalid, 1'b1);
    chk1("start_b_tvalid", sif.b_tvalid, 1'b1);
    chk1("start_c_tready", sif.c_tready, 1'b1);
    chk1("start_timeout_clr", timeout_o, 1'b0);
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clk);
      if (ap_done) begin
        done_cyc = k;
        break;
      end
      if (rst_after != 0 && na == rst_after) begin
        early = 1'b1;
        break;
      end
      ld_we        = ld_mid && (k == 2);
      ld_sel       = 1'b0;
      ld_addr      = 4'd3;
      ld_data      = '1;
      sif.a_tready = a_bp ? (k % 2 == 0) : 1'b1;
      sif.b_tready = 1'b1;
      sif.c_tvalid = c_on && (nc < 16);
      sif.c_tdata  = 256'h100 + 256'(nc);
`ifdef DRIVER_TLAST_EN
      sif.c_tlast  = c_last_bad ? (nc == 14) : (nc == 15);
`endif
      if (na < 16) begin
        if (sif.a_tvalid) begin
          chk("a_tdata", 256'(sif.a_tdata), 256'(exp_a[na]));
`ifdef DRIVER_TLAST_EN
          chk1("a_tlast", sif.a_tlast, na == 15);
`endif
        end
      end else chk1("a_tvalid_after_last", sif.a_tvalid, 1'b0);
      if (nb < 16) begin
        if (sif.b_tvalid) chk("b_tdata", 256'(sif.b_tdata), 256'(exp_b[nb]));
      end else chk1("b_tvalid_after_last", sif.b_tvalid, 1'b0);
      if (nc >= 16) chk1("c_tready_after_last", sif.c_tready, 1'b0);
      if (sif.a_tvalid && sif.a_tready) na++;
      if (sif.b_tvalid && sif.b_tready) nb++;
      if (sif.c_tvalid && sif.c_tready) nc++;
    end
    ld_we        = 1'b0;
    sif.a_tready = 1'b0;
    sif.b_tready = 1'b0;
    sif.c_tvalid = 1'b0;
    if (!early) begin
      chki("done_seen", int'(done_cyc > 0), 1);
      chki("a_beats", na, 16);
      chki("b_beats", nb, 16);
      chki("c_beats", nc, c_on ? 16 : 0);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    ap_start = 1'b0; rd_addr = '0;
    sif.a_tready = 1'b0; sif.b_tready = 1'b0; sif.c_tvalid = 1'b0; sif.c_tdata = '0;
`ifdef DRIVER_TLAST_EN
    sif.c_tlast = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state.
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ap_done", ap_done, 1'b0);
    chk1("rst_timeout", timeout_o, 1'b0);
    chki("rst_cycles", int'(cycles), 0);
    chk("rst_rd_data", rd_data, 256'h0);
    chk1("rst_a_tvalid", sif.a_tvalid, 1'b0);
    chk1("rst_b_tvalid", sif.b_tvalid, 1'b0);
    chk1("rst_c_tready", sif.c_tready, 1'b0);
`ifdef DRIVER_TLAST_EN
    chk1("rst_tlast_err", tlast_err, 1'b0);
`endif
    rst = 1'b0;

    // Load identity A rows and B columns 0x01..0x10.
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = 128'h1 << (8 * i);
      exp_b[i] = {16{8'(i + 1)}};
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_sel  = (i >= 16);
      ld_addr = 4'(i % 16);
      ld_data = (i >= 16) ? exp_b[i % 16] : exp_a[i % 16];
    end
    @(negedge clk);
    ld_we = 1'b0;
    chk("idle_a_row0", 256'(sif.a_tdata), 256'(exp_a[0]));
    chk("idle_b_row0", 256'(sif.b_tdata), 256'(exp_b[0]));

    // Identity run, back-to-back partner.
    do_run(1'b0, 1'b1, 1'b0, 0, 1'b0, dc);
    chki("id_done_cycle", dc, 17);
    chki("id_cycles", int'(cycles), 16);
    chk1("id_timeout", timeout_o, 1'b0);
`ifdef DRIVER_TLAST_EN
    chk1("id_tlast_err", tlast_err, 1'b0);
`endif
    rd_addr = 4'd5;
    @(negedge clk);
    chk1("id_done_pulse", ap_done, 1'b0);
    chk("id_rd5", rd_data, 256'h105);
    rd_addr = 4'd15;
    @(negedge clk);
    chk("id_rd15", rd_data, 256'h10f);

    // A backpressure: a_tready low on odd cycles, high on even.
    do_run(1'b1, 1'b1, 1'b0, 0, 1'b0, dc);
    chki("bp_done_cycle", dc, 33);
    chki("bp_cycles", int'(cycles), 32);

    // Timeout: partner never returns C.
    do_run(1'b0, 1'b0, 1'b0, 0, 1'b0, dc);
    chki("to_done_cycle", dc, 65);
    chki("to_cycles", int'(cycles), 64);
    chk1("to_timeout", timeout_o, 1'b1);
    rd_addr = 4'd5;
    @(negedge clk);
    chk("to_rd5_kept", rd_data, 256'h105);
    chk1("to_timeout_held", timeout_o, 1'b1);

    // Reset after 5 A beats (the start inside also checks timeout is cleared).
    do_run(1'b0, 1'b1, 1'b0, 5, 1'b0, dc);
    rst = 1'b1;
    @(negedge clk);
    chk1("mid_rst_a_tvalid", sif.a_tvalid, 1'b0);
    chk1("mid_rst_b_tvalid", sif.b_tvalid, 1'b0);
    chk1("mid_rst_c_tready", sif.c_tready, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ap_done", ap_done, 1'b0);
    chk("mid_rst_a_row0", 256'(sif.a_tdata), 256'(exp_a[0]));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("mid_rst_no_done", ap_done, 1'b0);
    end
    do_run(1'b0, 1'b1, 1'b0, 0, 1'b0, dc);
    chki("restart_done_cycle", dc, 17);

    // Load gating: A row 3 write during RUN is dropped, the same write in IDLE sticks.
    do_run(1'b0, 1'b1, 1'b1, 0, 1'b0, dc);
    chki("gate_done_cycle", dc, 17);
    @(negedge clk);
    ld_we = 1'b1; ld_sel = 1'b0; ld_addr = 4'd3; ld_data = '1;
    @(negedge clk);
    ld_we = 1'b0;
    exp_a[3] = '1;
    do_run(1'b0, 1'b1, 1'b0, 0, 1'b0, dc);
    chki("gate2_done_cycle", dc, 17);

`ifdef DRIVER_TLAST_EN
    do_run(1'b0, 1'b1, 1'b0, 0, 1'b1, dc);
    chk1("tlast_err_set", tlast_err, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
